// File: rtl/decimal_keypad_bcd_encoder_if.sv
// ---------------------------------------------------------------------------
// decimal_keypad_bcd_encoder_if
// Bundles the keypad-side inputs and the BCD entry outputs of the
// decimal_keypad_bcd_encoder.
//   Decimal_In       10 key lines, bit k high = key k pressed
//   Clear            synchronous clear of the entry register and digit count
//   BCD_Digit        last accepted digit (0..9)
//   Digit_Valid      one-cycle strobe on each accepted digit
//   BCD_Value        packed BCD entry, newest digit in [3:0]
//   Digit_Count      number of digits entered, saturating at NUM_DIGITS
//   Multi_Key_Error  one-cycle strobe when several keys are pressed at once
//   Key_Held         high while a debounced release is awaited
// master: the keypad/consumer side. slave: the encoder.
// ---------------------------------------------------------------------------
interface decimal_keypad_bcd_encoder_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int DC_W  = $clog2(NUM_DIGITS + 1);
  localparam int VAL_W = 4 * NUM_DIGITS;

  logic [9:0]       Decimal_In;
  logic             Clear;
  logic [3:0]       BCD_Digit;
  logic             Digit_Valid;
  logic [VAL_W-1:0] BCD_Value;
  logic [DC_W-1:0]  Digit_Count;
  logic             Multi_Key_Error;
  logic             Key_Held;

  modport master (
    output Decimal_In, Clear,
    input  BCD_Digit, Digit_Valid, BCD_Value, Digit_Count, Multi_Key_Error, Key_Held
  );

  modport slave (
    input  Decimal_In, Clear,
    output BCD_Digit, Digit_Valid, BCD_Value, Digit_Count, Multi_Key_Error, Key_Held
  );
endinterface

// File: rtl/decimal_keypad_bcd_encoder.sv
// ---------------------------------------------------------------------------
// decimal_keypad_bcd_encoder
// Encodes debounced single-key presses from a ten-line decimal keypad into
// BCD digits and shifts each accepted digit into a packed-BCD entry register.
// A press must be stable for DEBOUNCE_CYCLES samples to be accepted, and the
// keypad must then read all-zero for DEBOUNCE_CYCLES samples before the next
// press is looked at. Multiple simultaneous keys raise a one-cycle error.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, highest priority
//   bus  slave side of decimal_keypad_bcd_encoder_if (keys, Clear, outputs)
// All outputs are registered.
// ---------------------------------------------------------------------------
module decimal_keypad_bcd_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_DIGITS      = 4
) (
  input logic clk,
  input logic rst,
  decimal_keypad_bcd_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DC_W  = $clog2(NUM_DIGITS + 1);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [DC_W-1:0]  DIGIT_MAX = DC_W'(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_ONE   = 2'd1,
    CLS_MULTI = 2'd2
  } key_class_t;

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s, cnt_inc_s;
  logic [3:0]       key_r, key_next_s;

  key_class_t       key_class_s;
  logic [3:0]       ones_s;
  logic [3:0]       key_idx_s;
  logic             accept_s;
  logic             multi_s;

  logic [3:0]       digit_r;
  logic             digit_valid_r;
  logic [VAL_W-1:0] value_r, value_next_s, value_shift_s;
  logic [DC_W-1:0]  count_r, count_next_s;
  logic             multi_err_r;
  logic             key_held_r;

  // Classify the key lines (none/one/multi) and encode the pressed key index.
  always_comb begin
    ones_s    = 4'd0;
    key_idx_s = 4'd0;
    for (int k = 0; k < 10; k++) begin
      ones_s = ones_s + {3'b000, bus.Decimal_In[k]};
      if (bus.Decimal_In[k]) begin
        key_idx_s = 4'(k);
      end else begin
        key_idx_s = key_idx_s;
      end
    end
    if (ones_s == 4'd0) begin
      key_class_s = CLS_NONE;
    end else if (ones_s == 4'd1) begin
      key_class_s = CLS_ONE;
    end else begin
      key_class_s = CLS_MULTI;
    end
  end

  // FSM state, debounce counter and captured-key registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      key_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      key_r   <= key_next_s;
    end
  end

  // Next-state logic: debounce the press, then debounce the release.
  // The same counter tracks stable-press samples in DEBOUNCE and
  // consecutive all-zero samples in RELEASE.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    key_next_s   = key_r;
    accept_s     = 1'b0;
    multi_s      = 1'b0;
    cnt_inc_s    = cnt_r + CNT_W'(1);
    case (state_r)
      IDLE: begin
        case (key_class_s)
          CLS_NONE: begin
            state_next_s = IDLE;
          end
          CLS_ONE: begin
            key_next_s = key_idx_s;
            if (DEBOUNCE_CYCLES == 1) begin
              accept_s     = 1'b1;
              cnt_next_s   = '0;
              state_next_s = RELEASE;
            end else begin
              cnt_next_s   = CNT_W'(1);
              state_next_s = DEBOUNCE;
            end
          end
          CLS_MULTI: begin
            multi_s      = 1'b1;
            cnt_next_s   = '0;
            state_next_s = RELEASE;
          end
          default: begin
            state_next_s = IDLE;
          end
        endcase
      end
      DEBOUNCE: begin
        if (key_class_s == CLS_MULTI) begin
          multi_s      = 1'b1;
          cnt_next_s   = '0;
          state_next_s = RELEASE;
        end else if ((key_class_s == CLS_ONE) && (key_idx_s == key_r)) begin
          if (cnt_inc_s == DEB_LAST) begin
            accept_s     = 1'b1;
            cnt_next_s   = '0;
            state_next_s = RELEASE;
          end else begin
            cnt_next_s   = cnt_inc_s;
          end
        end else begin
          // Bounce or a different key: start over, the new key is not captured here.
          cnt_next_s   = '0;
          state_next_s = IDLE;
        end
      end
      RELEASE: begin
        if (key_class_s == CLS_NONE) begin
          if (cnt_inc_s == DEB_LAST) begin
            cnt_next_s   = '0;
            state_next_s = IDLE;
          end else begin
            cnt_next_s   = cnt_inc_s;
          end
        end else begin
          cnt_next_s = '0;
        end
      end
      default: begin
        cnt_next_s   = '0;
        state_next_s = IDLE;
      end
    endcase
  end

  // Entry register update: shift on accept, Clear only empties it when no
  // digit is being accepted on the same edge.
  always_comb begin
    value_shift_s = value_r << 4;
    value_next_s  = value_r;
    count_next_s  = count_r;
    if (accept_s) begin
      if (bus.Clear) begin
        value_next_s = VAL_W'(key_idx_s);
        count_next_s = DC_W'(1);
      end else begin
        value_next_s = value_shift_s | VAL_W'(key_idx_s);
        if (count_r == DIGIT_MAX) begin
          count_next_s = count_r;
        end else begin
          count_next_s = count_r + DC_W'(1);
        end
      end
    end else if (bus.Clear) begin
      value_next_s = '0;
      count_next_s = '0;
    end else begin
      value_next_s = value_r;
      count_next_s = count_r;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_r       <= 4'd0;
      digit_valid_r <= 1'b0;
      value_r       <= '0;
      count_r       <= '0;
      multi_err_r   <= 1'b0;
      key_held_r    <= 1'b0;
    end else begin
      digit_valid_r <= accept_s;
      multi_err_r   <= multi_s;
      key_held_r    <= (state_next_s == RELEASE);
      value_r       <= value_next_s;
      count_r       <= count_next_s;
      if (accept_s) begin
        digit_r <= key_idx_s;
      end
    end
  end

  assign bus.BCD_Digit       = digit_r;
  assign bus.Digit_Valid     = digit_valid_r;
  assign bus.BCD_Value       = value_r;
  assign bus.Digit_Count     = count_r;
  assign bus.Multi_Key_Error = multi_err_r;
  assign bus.Key_Held        = key_held_r;

endmodule

// File: tb/tb_decimal_keypad_bcd_encoder.sv
// ---------------------------------------------------------------------------
// tb_decimal_keypad_bcd_encoder
// Directed bench for decimal_keypad_bcd_encoder with DEBOUNCE_CYCLES=4 and
// NUM_DIGITS=4. Inputs change 1 ns after a rising edge; outputs are read at
// the same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_decimal_keypad_bcd_encoder;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  decimal_keypad_bcd_encoder_if #(.NUM_DIGITS(4)) bus ();

  decimal_keypad_bcd_encoder #(
    .DEBOUNCE_CYCLES(4),
    .NUM_DIGITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold key k for four edges (a full debounce) with no checking.
  task automatic press(input int k);
    bus.Decimal_In = 10'd1 << k;
    repeat (3) tick();
    tick();
  endtask

  task automatic release_keys();
    bus.Decimal_In = 10'd0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Clear = 1'b0;
    bus.Decimal_In = 10'h3FF;
    tick();
    tick();
    n_vec++;
    if ({bus.BCD_Digit, bus.Digit_Valid, bus.BCD_Value, bus.Digit_Count,
         bus.Multi_Key_Error, bus.Key_Held} !== 26'd0) begin
      $display("FAIL reset_outputs: got digit=%0h dv=%0b val=%0h cnt=%0d err=%0b held=%0b, expected all 0",
               bus.BCD_Digit, bus.Digit_Valid, bus.BCD_Value, bus.Digit_Count,
               bus.Multi_Key_Error, bus.Key_Held);
      n_err++;
    end
    rst = 1'b0;
    bus.Decimal_In = 10'd0;
    tick();
    n_vec++;
    if (bus.Multi_Key_Error !== 1'b0 || bus.Key_Held !== 1'b0) begin
      $display("FAIL reset_idle: got err=%0b held=%0b, expected 0 0", bus.Multi_Key_Error, bus.Key_Held);
      n_err++;
    end
  endtask

  task automatic test_clean_press();
    bus.Decimal_In = 10'b0010000000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_vec++;
      if (bus.Digit_Valid !== (i == 4)) begin
        $display("FAIL clean_dv[%0d]: got %0b, expected %0b", i, bus.Digit_Valid, (i == 4));
        n_err++;
      end
      n_vec++;
      if (bus.Key_Held !== (i >= 4)) begin
        $display("FAIL clean_held[%0d]: got %0b, expected %0b", i, bus.Key_Held, (i >= 4));
        n_err++;
      end
      if (i == 4) begin
        n_vec++;
        if (bus.BCD_Digit !== 4'h7 || bus.BCD_Value !== 16'h0007 || bus.Digit_Count !== 3'd1) begin
          $display("FAIL clean_accept: got digit=%0h val=%04h cnt=%0d, expected 7 0007 1",
                   bus.BCD_Digit, bus.BCD_Value, bus.Digit_Count);
          n_err++;
        end
      end
    end
    bus.Decimal_In = 10'd0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      n_vec++;
      if (bus.Key_Held !== (j < 4) || bus.Digit_Valid !== 1'b0) begin
        $display("FAIL clean_release[%0d]: got held=%0b dv=%0b, expected held=%0b dv=0",
                 j, bus.Key_Held, bus.Digit_Valid, (j < 4));
        n_err++;
      end
    end
  endtask

  task automatic test_bounce();
    bus.Decimal_In = 10'b0000001000;
    tick();
    tick();
    bus.Decimal_In = 10'd0;
    tick();
    bus.Decimal_In = 10'b0000001000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (bus.Digit_Valid !== (i == 4)) begin
        $display("FAIL bounce_dv[%0d]: got %0b, expected %0b", i, bus.Digit_Valid, (i == 4));
        n_err++;
      end
    end
    n_vec++;
    if (bus.BCD_Digit !== 4'h3 || bus.BCD_Value !== 16'h0073 || bus.Digit_Count !== 3'd2) begin
      $display("FAIL bounce_accept: got digit=%0h val=%04h cnt=%0d, expected 3 0073 2",
               bus.BCD_Digit, bus.BCD_Value, bus.Digit_Count);
      n_err++;
    end
    release_keys();
  endtask

  task automatic test_multi_digit();
    logic [15:0] exp_val [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234, 16'h2345};
    logic [2:0]  exp_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    n_vec++;
    if (bus.BCD_Value !== 16'h0000 || bus.Digit_Count !== 3'd0 || bus.BCD_Digit !== 4'h3) begin
      $display("FAIL clear_idle: got val=%04h cnt=%0d digit=%0h, expected 0000 0 3",
               bus.BCD_Value, bus.Digit_Count, bus.BCD_Digit);
      n_err++;
    end
    for (int d = 0; d < 5; d++) begin
      press(d + 1);
      n_vec++;
      if (bus.Digit_Valid !== 1'b1 || bus.BCD_Value !== exp_val[d] || bus.Digit_Count !== exp_cnt[d]) begin
        $display("FAIL entry[%0d]: got dv=%0b val=%04h cnt=%0d, expected 1 %04h %0d",
                 d, bus.Digit_Valid, bus.BCD_Value, bus.Digit_Count, exp_val[d], exp_cnt[d]);
        n_err++;
      end
      release_keys();
    end
  endtask

  task automatic test_multi_key();
    bus.Decimal_In = 10'b0000100001;
    tick();
    n_vec++;
    if (bus.Multi_Key_Error !== 1'b1 || bus.Digit_Valid !== 1'b0 || bus.Key_Held !== 1'b1) begin
      $display("FAIL multi_pulse: got err=%0b dv=%0b held=%0b, expected 1 0 1",
               bus.Multi_Key_Error, bus.Digit_Valid, bus.Key_Held);
      n_err++;
    end
    tick();
    n_vec++;
    if (bus.Multi_Key_Error !== 1'b0 || bus.Key_Held !== 1'b1) begin
      $display("FAIL multi_one_cycle: got err=%0b held=%0b, expected 0 1", bus.Multi_Key_Error, bus.Key_Held);
      n_err++;
    end
    release_keys();
    n_vec++;
    if (bus.Key_Held !== 1'b0) begin
      $display("FAIL multi_released: got held=%0b, expected 0", bus.Key_Held);
      n_err++;
    end
    press(9);
    n_vec++;
    if (bus.Digit_Valid !== 1'b1 || bus.BCD_Digit !== 4'h9 || bus.BCD_Value !== 16'h3459) begin
      $display("FAIL multi_then_9: got dv=%0b digit=%0h val=%04h, expected 1 9 3459",
               bus.Digit_Valid, bus.BCD_Digit, bus.BCD_Value);
      n_err++;
    end
    release_keys();
  endtask

  task automatic test_key_change();
    bus.Decimal_In = 10'b0000000100;
    tick();
    tick();
    bus.Decimal_In = 10'b0001000000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_vec++;
      if (bus.Digit_Valid !== (i == 5)) begin
        $display("FAIL change_dv[%0d]: got %0b, expected %0b", i, bus.Digit_Valid, (i == 5));
        n_err++;
      end
    end
    n_vec++;
    if (bus.BCD_Digit !== 4'h6 || bus.BCD_Value !== 16'h4596) begin
      $display("FAIL change_accept: got digit=%0h val=%04h, expected 6 4596", bus.BCD_Digit, bus.BCD_Value);
      n_err++;
    end
    release_keys();
  endtask

  task automatic test_clear_on_accept();
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      press(d);
      release_keys();
    end
    n_vec++;
    if (bus.BCD_Value !== 16'h1234) begin
      $display("FAIL clear_setup: got val=%04h, expected 1234", bus.BCD_Value);
      n_err++;
    end
    bus.Decimal_In = 10'b0100000000;
    repeat (3) tick();
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    n_vec++;
    if (bus.Digit_Valid !== 1'b1 || bus.BCD_Value !== 16'h0008 || bus.Digit_Count !== 3'd1) begin
      $display("FAIL clear_accept: got dv=%0b val=%04h cnt=%0d, expected 1 0008 1",
               bus.Digit_Valid, bus.BCD_Value, bus.Digit_Count);
      n_err++;
    end
    release_keys();
  endtask

  task automatic test_reset_mid_debounce();
    bus.Decimal_In = 10'b0000100000;
    tick();
    tick();
    rst = 1'b1;
    bus.Decimal_In = 10'd0;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({bus.BCD_Digit, bus.Digit_Valid, bus.BCD_Value, bus.Digit_Count,
         bus.Multi_Key_Error, bus.Key_Held} !== 26'd0) begin
      $display("FAIL reset_mid: got digit=%0h dv=%0b val=%04h cnt=%0d err=%0b held=%0b, expected all 0",
               bus.BCD_Digit, bus.Digit_Valid, bus.BCD_Value, bus.Digit_Count,
               bus.Multi_Key_Error, bus.Key_Held);
      n_err++;
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (bus.Digit_Valid !== 1'b0) begin
        $display("FAIL reset_mid_dv[%0d]: got %0b, expected 0", i, bus.Digit_Valid);
        n_err++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_digit();
    test_multi_key();
    test_key_change();
    test_clear_on_accept();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decimal_keypad_bcd_encoder.md
Name: decimal_keypad_bcd_encoder

Overview:
- Inverse of the team's BCD-to-decimal decoder: takes ten one-line-per-key decimal inputs (0..9) from a keypad and encodes each debounced press into a 4-bit BCD digit.
- Accepted digits shift into a multi-digit packed-BCD entry register, so the block acts as the front end of a numeric-entry path.
- Provides press debouncing, release debouncing, multi-key error detection and a one-cycle digit-valid strobe.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a press or a release (legal range >= 1).
- NUM_DIGITS, 4, number of BCD digits held in the entry register (legal range >= 1).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Decimal_In  input  10  key lines; bit k high = key k pressed. Assumed synchronous to clk.
- Clear  input  1  synchronous clear of the entry register and digit count.
- BCD_Digit  output  4  last accepted digit (0..9), held until the next accept.
- Digit_Valid  output  1  one-cycle pulse when a digit is accepted.
- BCD_Value  output  4*NUM_DIGITS  packed BCD entry. Newest digit is in [3:0].
- Digit_Count  output  $clog2(NUM_DIGITS+1)  digits entered, saturating at NUM_DIGITS.
- Multi_Key_Error  output  1  one-cycle pulse when more than one key line is high during a press.
- Key_Held  output  1  high while the block waits for a debounced release.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, counter=0, captured key=0. All outputs are 0. rst has priority over everything.
- Input classes, evaluated each edge: NONE (all zero), ONE (exactly one bit set), MULTI (two or more bits set).
- FSM states: IDLE, DEBOUNCE, RELEASE.
- IDLE, on each class:
  - NONE: stay in IDLE.
  - ONE: capture the key index and set cnt=1. If DEBOUNCE_CYCLES==1, accept immediately and go to RELEASE; otherwise go to DEBOUNCE.
  - MULTI: pulse Multi_Key_Error and go to RELEASE.
- DEBOUNCE, on each class:
  - ONE with the same key: cnt++. When cnt reaches DEBOUNCE_CYCLES, accept and go to RELEASE.
  - ONE with a different key, or NONE: go to IDLE with no output. A different key is not captured on this edge.
  - MULTI: pulse Multi_Key_Error and go to RELEASE.
- RELEASE:
  - Key_Held=1 throughout this state.
  - Counts consecutive NONE samples; any nonzero sample resets the count to 0.
  - No error is reported in RELEASE (key roll-over is ignored).
  - After DEBOUNCE_CYCLES consecutive NONE samples, go to IDLE. The next press can be captured on the edge after that.
- Accept, registered on the accepting edge and visible in the following cycle:
  - Digit_Valid=1 for exactly one cycle.
  - BCD_Digit = key index in binary.
  - BCD_Value = {BCD_Value[4*NUM_DIGITS-5:0], digit}; the oldest digit is discarded.
  - Digit_Count increments, saturating at NUM_DIGITS.
- Latency: with a key stable before edge 1, Digit_Valid is high in the cycle after edge DEBOUNCE_CYCLES.
- Holding a key longer produces no repeat accept. One accept per press/release cycle.
- Clear without an accept: BCD_Value=0 and Digit_Count=0 on that edge. FSM, BCD_Digit and Key_Held are unaffected.
- Clear on the same edge as an accept: BCD_Value={0..., digit}, Digit_Count=1, and Digit_Valid still pulses.
- Reset mid-DEBOUNCE or mid-RELEASE: returns to IDLE with no Digit_Valid pulse and clears all outputs.
- Multi_Key_Error and Digit_Valid are never high in the same cycle.
- Encoded output never exceeds 9. Inputs 10..15 cannot occur by construction.

Test Plan:
- Reset: assert rst for 2 cycles with Decimal_In=10'h3FF -> all outputs 0, no error pulse, state IDLE.
- Clean press (DEBOUNCE_CYCLES=4): Decimal_In=10'b0010000000 (key 7) held 20 cycles, then 0 for 6 cycles.
  - Exactly one Digit_Valid pulse, in the cycle after the 4th edge.
  - BCD_Digit=4'h7, BCD_Value=16'h0007, Digit_Count=1.
  - Key_Held high until 4 zero samples have been seen.
- Bounce: key 3 for 2 cycles, 0 for 1, key 3 for 4 cycles, then release.
  - Exactly one accept, with BCD_Digit=4'h3, after the second burst's 4th edge.
  - No pulse during the first burst.
- Multi-digit entry: debounced presses 1,2,3,4,5 with full releases in between.
  - BCD_Value steps 0001, 0012, 0123, 1234, 2345 (hex).
  - Digit_Count steps 1..4 and stays at 4.
- Multi-key: Decimal_In=10'b0000100001 from IDLE.
  - Multi_Key_Error pulses for 1 cycle, no Digit_Valid, Key_Held=1.
  - After 4 zero cycles, a key-9 press is accepted with BCD_Digit=4'h9.
- Clear and reset corners:
  - Clear asserted on key 8's accepting edge with BCD_Value=16'h1234 -> BCD_Value=16'h0008, Digit_Count=1, Digit_Valid pulses.
  - rst at cnt=2 in DEBOUNCE -> no pulse, all outputs 0.
